mem_stage_combination: RTL and testbench

MEM_STAGE_COMBINATION -- requirements
Module: mem_stage_combination

---
 rtl/mem_stage_combination.sv | 76 +++++++
 tb/tb_mem_stage_combination.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mem_stage_combination.sv
// MEM pipeline stage: 256x32 data memory, branch resolution and the MEM/WB register.
// Optional misaligned-access detection is enabled by defining MEM_MISALIGN_CHK_EN.
module mem_stage_combination (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  EX_MEM_wb_ctlout,
  input  logic [2:0]  EX_MEM_m_ctlout,
  input  logic [31:0] EX_MEM_add_result,
  input  logic [0:0]  EX_MEM_zero,
  input  logic [31:0] EX_MEM_alu_result,
  input  logic [31:0] EX_MEM_rdata2out,
  input  logic [4:0]  EX_MEM_five_bit_muxout,
  input  logic        stall,
  output logic [0:0]  PCSrc,
  output logic [31:0] branch_target,
  output logic [1:0]  MEM_WB_wb_ctlout,
  output logic [31:0] MEM_WB_read_data,
  output logic [31:0] MEM_WB_alu_result,
  output logic [4:0]  MEM_WB_five_bit_muxout
`ifdef MEM_MISALIGN_CHK_EN
  ,
  output logic        misalign_err
`endif
);

  logic        branch, memread, memwrite;
  logic [7:0]  idx;
  logic        misal;
  logic        wr_en;
  logic        unused_addr_bits;
  logic [31:0] mem [256];

  assign {branch, memread, memwrite} = EX_MEM_m_ctlout;
  assign idx = EX_MEM_alu_result[9:2];
  assign unused_addr_bits = ^{EX_MEM_alu_result[31:10], EX_MEM_alu_result[1:0]};

`ifdef MEM_MISALIGN_CHK_EN
  assign misal = (memread | memwrite) & (|EX_MEM_alu_result[1:0]);
`else
  assign misal = 1'b0;
`endif

  assign wr_en = memwrite & ~stall & ~misal;

  assign PCSrc         = branch & EX_MEM_zero;
  assign branch_target = EX_MEM_add_result;

  // Memory contents are never reset; rst_n only gates the write strobe.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) mem[idx] <= EX_MEM_rdata2out;
  end

  // Read sees the pre-write word because the array update is non-blocking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      MEM_WB_wb_ctlout       <= '0;
      MEM_WB_read_data       <= '0;
      MEM_WB_alu_result      <= '0;
      MEM_WB_five_bit_muxout <= '0;
    end else if (!stall) begin
      MEM_WB_wb_ctlout       <= EX_MEM_wb_ctlout;
      MEM_WB_read_data       <= (memread && !misal) ? mem[idx] : 32'h0;
      MEM_WB_alu_result      <= EX_MEM_alu_result;
      MEM_WB_five_bit_muxout <= EX_MEM_five_bit_muxout;
    end
  end

`ifdef MEM_MISALIGN_CHK_EN
  // Sticky: only reset clears it. A stalled access is not performed, so it does not flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              misalign_err <= 1'b0;
    else if (!stall && misal) misalign_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_mem_stage_combination.sv
// Bench for mem_stage_combination: directed scenarios plus random traffic against a word-array model.
// Define MEM_MISALIGN_CHK_EN for both files to exercise the misalignment checker.
module tb_mem_stage_combination;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  wb_in;
  logic [2:0]  m_in;
  logic [31:0] add_in, alu_in, data_in;
  logic [0:0]  zero_in;
  logic [4:0]  r5_in;
  logic        stall;
  logic [0:0]  PCSrc;
  logic [31:0] branch_target, rd_out, alu_out;
  logic [1:0]  wb_out;
  logic [4:0]  r5_out;
`ifdef MEM_MISALIGN_CHK_EN
  logic        misalign_err;
`endif

  always #5 clk = ~clk;

  mem_stage_combination dut (
    .clk(clk), .rst_n(rst_n),
    .EX_MEM_wb_ctlout(wb_in), .EX_MEM_m_ctlout(m_in), .EX_MEM_add_result(add_in),
    .EX_MEM_zero(zero_in), .EX_MEM_alu_result(alu_in), .EX_MEM_rdata2out(data_in),
    .EX_MEM_five_bit_muxout(r5_in), .stall(stall),
    .PCSrc(PCSrc), .branch_target(branch_target),
    .MEM_WB_wb_ctlout(wb_out), .MEM_WB_read_data(rd_out),
    .MEM_WB_alu_result(alu_out), .MEM_WB_five_bit_muxout(r5_out)
`ifdef MEM_MISALIGN_CHK_EN
    , .misalign_err(misalign_err)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Reference model: word array plus expected MEM/WB contents.
  logic [31:0] m [256];
  logic [1:0]  e_wb;
  logic [31:0] e_rd, e_alu;
  logic [4:0]  e_r5;
  logic        e_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".wb"},  {30'h0, wb_out}, {30'h0, e_wb});
    chk({tag, ".rd"},  rd_out, e_rd);
    chk({tag, ".alu"}, alu_out, e_alu);
    chk({tag, ".r5"},  {27'h0, r5_out}, {27'h0, e_r5});
`ifdef MEM_MISALIGN_CHK_EN
    chk({tag, ".err"}, {31'h0, misalign_err}, {31'h0, e_err});
`endif
  endtask

  task automatic model_reset();
    e_wb = '0; e_rd = '0; e_alu = '0; e_r5 = '0; e_err = 1'b0;
  endtask

  // One cycle: drive at negedge, check combinational outputs, clock, check MEM/WB.
  task automatic step(input string tag, input logic [2:0] mc, input logic z,
                      input logic [31:0] addr, input logic [31:0] data, input logic [31:0] tgt,
                      input logic [1:0] wb, input logic [4:0] r5, input logic st);
    int  w;
    bit  bad;
    m_in = mc; zero_in = z; alu_in = addr; data_in = data; add_in = tgt;
    wb_in = wb; r5_in = r5; stall = st;
    #1;
    chk({tag, ".pcsrc"}, {31'h0, PCSrc}, {31'h0, (mc[2] && z)});
    chk({tag, ".tgt"}, branch_target, tgt);
    w = int'(addr[9:2]);
    bad = 1'b0;
`ifdef MEM_MISALIGN_CHK_EN
    bad = (mc[1] || mc[0]) && (addr[1:0] != 2'b00);
`endif
    if (!st) begin
      e_wb = wb; e_alu = addr; e_r5 = r5;
      e_rd = (mc[1] && !bad) ? m[w] : 32'h0;
      if (mc[0] && !bad) m[w] = data;
      if (bad) e_err = 1'b1;
    end
    @(posedge clk); #1;
    check_outs(tag);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] old, nw;
    rst_n = 1'b0; stall = 1'b0;
    m_in = '0; zero_in = '0; alu_in = '0; data_in = '0; add_in = '0; wb_in = '0; r5_in = '0;
    model_reset();
    #3;
    check_outs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Fill every word so later reads are defined (covers indices 0x00 and 0xFF).
    for (int i = 0; i < 256; i++)
      step("fill", 3'b001, 1'b0, {22'h0, i[7:0], 2'b00}, $urandom, 32'h0, 2'b00, 5'd0, 1'b0);

    // Store then load.
    step("st10", 3'b001, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 2'b11, 5'd3, 1'b0);
    step("ld10", 3'b010, 1'b0, 32'h10, 32'h0, 32'h0, 2'b10, 5'd4, 1'b0);
    chk("ld10.abs", rd_out, 32'hDEADBEEF);

    // Branch resolution is combinational.
    step("br_z1", 3'b100, 1'b1, 32'h0, 32'h0, 32'h40, 2'b00, 5'd0, 1'b0);
    step("br_z0", 3'b100, 1'b0, 32'h0, 32'h0, 32'h40, 2'b00, 5'd0, 1'b0);

    // Stalled store must not commit and MEM/WB must stay frozen.
    old = m[8];
    step("st20_stall", 3'b001, 1'b0, 32'h20, 32'h1234, 32'h0, 2'b01, 5'd9, 1'b1);
    step("ld20", 3'b010, 1'b0, 32'h20, 32'h0, 32'h0, 2'b01, 5'd9, 1'b0);
    chk("ld20.old", rd_out, old);

    // Read and write same index: old word out, new word committed.
    old = m[255]; nw = 32'hA5A5_0F0F;
    step("rw3fc", 3'b011, 1'b0, 32'h3FC, nw, 32'h0, 2'b10, 5'd31, 1'b0);
    chk("rw3fc.old", rd_out, old);
    step("ld3fc", 3'b010, 1'b0, 32'h3FC, 32'h0, 32'h0, 2'b10, 5'd31, 1'b0);
    chk("ld3fc.new", rd_out, nw);

    // High address bits are ignored.
    step("ld_hi", 3'b010, 1'b0, 32'hFFFF_FC10, 32'h0, 32'h0, 2'b00, 5'd1, 1'b0);

`ifdef MEM_MISALIGN_CHK_EN
    step("st13", 3'b001, 1'b0, 32'h13, 32'h0BAD_0BAD, 32'h0, 2'b00, 5'd0, 1'b0);
    chk("st13.err", {31'h0, misalign_err}, 32'h1);
    step("ld10b", 3'b010, 1'b0, 32'h10, 32'h0, 32'h0, 2'b00, 5'd0, 1'b0);
    chk("ld10b.keep", rd_out, 32'hDEADBEEF);
`endif

    // Random traffic.
    for (int i = 0; i < 300; i++)
      step("rand", 3'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
           2'($urandom), 5'($urandom), ($urandom_range(0, 4) == 0));

    // Reset mid-cycle with a store pending.
    old = m[12];
    m_in = 3'b001; alu_in = 32'h30; data_in = 32'h5555; stall = 1'b0;
    wb_in = 2'b11; r5_in = 5'd7;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outs("rst_mid");
    @(posedge clk); #1;
    check_outs("rst_edge");
    @(negedge clk);
    rst_n = 1'b1;
    step("ld30", 3'b010, 1'b0, 32'h30, 32'h0, 32'h0, 2'b00, 5'd0, 1'b0);
    chk("ld30.old", rd_out, old);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
